// File: rtl/rr_arbiter_ctrl.sv
// -----------------------------------------------------------------------------
// rr_arbiter_ctrl
//
// Round-robin arbiter sharing one downstream resource among N requesters.
// A winner is picked from the pending requests by scanning cyclically upward
// from a rotating priority pointer. The grant is registered and one-hot. A
// grant ends on the owner's done strobe, on the owner dropping its request, or
// when the hold limit is reached. Every release is followed by exactly one
// idle cycle, so muxed datapath selects driven by grant never overlap.
//
// Ports
//   clk      system clock, all state changes on the rising edge
//   r        asynchronous active-high reset
//   req      [N-1:0]  per-requester request level
//   done     [N-1:0]  per-requester release strobe (only the owner's bit counts)
//   grant    [N-1:0]  registered one-hot grant, all zero when idle
//   busy     1 while a grant is active (|grant)
//   owner    [OW-1:0] index of the current or most recently granted requester
//   timeout  one-cycle pulse in the idle cycle after a forced release
// -----------------------------------------------------------------------------
module rr_arbiter_ctrl #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 15,
  parameter int OW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          r,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  done,
  output logic [N-1:0]  grant,
  output logic          busy,
  output logic [OW-1:0] owner,
  output logic          timeout
);

  // Hold counter sized to reach MAX_HOLD; a single unused bit when the
  // timeout is disabled.
  localparam int            CW        = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam bit            HOLD_EN   = (MAX_HOLD > 0);
  localparam logic [CW-1:0] CNT_MAX   = CW'((MAX_HOLD > 0) ? MAX_HOLD : 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
  localparam logic [OW-1:0] LAST_IDX  = OW'(N - 1);
  // One extra bit so ptr + offset can be range-reduced without overflow.
  localparam int            SW        = OW + 1;
  localparam logic [SW-1:0] N_SUM     = SW'(N);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] ptr_q,   ptr_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          timeout_q, timeout_d;

  // Cyclic priority search starting at ptr_q.
  logic          found;
  logic [OW-1:0] winner;
  logic [SW-1:0] sum;
  logic [OW-1:0] idx;

  // NOTE: every signal written in an always_comb gets a default at the top of
  // the block; a path that leaves one unassigned would infer a latch.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr_q} + SW'(i);
      if (sum >= N_SUM) sum = sum - N_SUM;
      idx = sum[OW-1:0];
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Release causes for the current owner.
  logic rel_done, rel_drop, rel_hold, release_now;

  always_comb begin
    rel_done    = done[owner_q];
    rel_drop    = ~req[owner_q];
    rel_hold    = HOLD_EN && (cnt_q == HOLD_LAST);
    release_now = rel_done | rel_drop | rel_hold;
  end

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          grant_d = N'(1) << winner;
          owner_d = winner;
          cnt_d   = '0;
        end
      end

      GRANT: begin
        if (release_now) begin
          state_d   = IDLE;
          grant_d   = '0;
          ptr_d     = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
          // Forced release only when neither done nor a dropped request
          // would have ended the grant on this edge anyway.
          timeout_d = rel_hold & ~rel_done & ~rel_drop;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = |grant_q;
  assign owner   = owner_q;
  assign timeout = timeout_q;

endmodule
